// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with per-entry tlast and a first-word-fall-through output.
// Define AXIS_PKT_FIFO_STORE_FWD_EN to hold output until a whole packet is buffered.
module axis_pkt_fifo #(
   parameter  int DW    = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] s_tdata,
   input  logic          s_tvalid,
   input  logic          s_tlast,
   output logic          s_tready,
   output logic [DW-1:0] m_tdata,
   output logic          m_tvalid,
   output logic          m_tlast,
   input  logic          m_tready,
   output logic [AW:0]   count
);

   localparam logic [AW:0] ONE = 1;

   logic [DW:0] mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0] count_q, count_d;
   logic [DW:0] rd_entry;
   logic        full, empty, push, pop;

   // Equal low bits with differing MSBs means the writer is one lap ahead.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign s_tready = !full && !rst;
   assign push     = s_tvalid && s_tready;
   assign pop      = m_tvalid && m_tready;

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
   logic [AW:0] pkt_cnt_q, pkt_cnt_d;

   // The full term lets a packet longer than the FIFO drain instead of deadlocking.
   assign m_tvalid = !empty && ((pkt_cnt_q != '0) || full);

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      case ({push && s_tlast, pop && m_tlast})
         2'b10:   pkt_cnt_d = pkt_cnt_q + ONE;
         2'b01:   pkt_cnt_d = pkt_cnt_q - ONE;
         default: pkt_cnt_d = pkt_cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pkt_cnt_q <= '0;
      else     pkt_cnt_q <= pkt_cnt_d;
   end
`else
   assign m_tvalid = !empty;
`endif

   assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];
   assign m_tdata  = m_tvalid ? rd_entry[DW-1:0] : '0;
   assign m_tlast  = m_tvalid && rd_entry[DW];
   assign count    = count_q;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + ONE;
      case ({push, pop})
         2'b10:   count_d = count_q + ONE;
         2'b01:   count_d = count_q - ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; stale entries are never visible because the outputs are gated.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= {s_tlast, s_tdata};
   end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Self-checking bench for axis_pkt_fifo: vector table, corner-case sequences and a data scoreboard.
// Store-and-forward sequences run when AXIS_PKT_FIFO_STORE_FWD_EN is defined.
module tb_axis_pkt_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
   localparam bit SF = 1'b1;
`else
   localparam bit SF = 1'b0;
`endif

   logic          clk, rst;
   logic [DW-1:0] s_tdata, m_tdata;
   logic          s_tvalid, s_tlast, s_tready;
   logic          m_tvalid, m_tlast, m_tready;
   logic [AW:0]   count;

   int            checks = 0;
   int            errors = 0;
   logic [DW:0]   sb_q[$];
   logic [DW-1:0] last_pop_data = '0;

   typedef struct {
      logic          sv;
      logic          sl;
      logic [DW-1:0] sd;
      logic          mr;
      logic [AW:0]   c;
      logic          mv;
      logic [DW-1:0] md;
      logic          ml;
      logic          sr;
   } vec_t;

   vec_t vecs[6];

   axis_pkt_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .s_tdata  (s_tdata),
      .s_tvalid (s_tvalid),
      .s_tlast  (s_tlast),
      .s_tready (s_tready),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tlast  (m_tlast),
      .m_tready (m_tready),
      .count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Handshakes are observed mid-cycle, where inputs and outputs are both settled.
   always @(negedge clk) begin
      if (!rst) begin
         if (m_tvalid && m_tready) begin
            check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
               check("sb_data", 32'({m_tlast, m_tdata}), 32'(sb_q.pop_front()));
               last_pop_data = m_tdata;
            end
         end
         if (s_tvalid && s_tready) sb_q.push_back({s_tlast, s_tdata});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input logic [DW-1:0] exp_last);
      m_tready = 1'b1;
      for (int n = 0; n < 64 && count != 0; n++) tick();
      m_tready = 1'b0;
      check("drain_count", 32'(count), 32'd0);
      check("drain_last", 32'(last_pop_data), 32'(exp_last));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic acc, seen;
      int   idx;

      vecs[0] = '{1'b1, 1'b0, 8'h11, 1'b0, 5'd1, !SF, SF ? 8'h00 : 8'h11, 1'b0, 1'b1};
      vecs[1] = '{1'b1, 1'b0, 8'h22, 1'b0, 5'd2, !SF, SF ? 8'h00 : 8'h11, 1'b0, 1'b1};
      vecs[2] = '{1'b1, 1'b1, 8'h33, 1'b0, 5'd3, 1'b1, 8'h11, 1'b0, 1'b1};
      vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd2, 1'b1, 8'h22, 1'b0, 1'b1};
      vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 1'b1, 8'h33, 1'b1, 1'b1};
      vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1};

      rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b0;
      #2;
      check("rst_s_tready", 32'(s_tready), 32'd0);
      check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      check("rst_m_tdata",  32'(m_tdata),  32'd0);
      check("rst_m_tlast",  32'(m_tlast),  32'd0);
      check("rst_count",    32'(count),    32'd0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      #1 check("post_rst_s_tready", 32'(s_tready), 32'd1);
      tick();

      // Basic three-word packet, then drained back-to-back.
      foreach (vecs[i]) begin
         s_tvalid = vecs[i].sv; s_tlast = vecs[i].sl; s_tdata = vecs[i].sd; m_tready = vecs[i].mr;
         tick();
         check($sformatf("v%0d_count", i),    32'(count),    32'(vecs[i].c));
         check($sformatf("v%0d_m_tvalid", i), 32'(m_tvalid), 32'(vecs[i].mv));
         check($sformatf("v%0d_m_tdata", i),  32'(m_tdata),  32'(vecs[i].md));
         check($sformatf("v%0d_m_tlast", i),  32'(m_tlast),  32'(vecs[i].ml));
         check($sformatf("v%0d_s_tready", i), 32'(s_tready), 32'(vecs[i].sr));
      end
      s_tvalid = 1'b0; m_tready = 1'b0;

      // Fill to full, attempt an overflow push, free one slot and refill.
      for (int i = 0; i < DEPTH; i++) begin
         s_tvalid = 1'b1; s_tdata = 8'(8'h40 + i); s_tlast = (i == DEPTH - 1);
         tick();
      end
      check("full_count", 32'(count), 32'd16);
      check("full_s_tready", 32'(s_tready), 32'd0);
      s_tdata = 8'hEE; s_tlast = 1'b0;
      tick();
      check("overflow_count", 32'(count), 32'd16);
      s_tvalid = 1'b0; m_tready = 1'b1;
      tick();
      m_tready = 1'b0;
      check("pop_from_full_s_tready", 32'(s_tready), 32'd1);
      check("pop_from_full_count", 32'(count), 32'd15);
      s_tvalid = 1'b1; s_tdata = 8'hAA; s_tlast = 1'b1;
      tick();
      s_tvalid = 1'b0; s_tlast = 1'b0;
      check("refill_count", 32'(count), 32'd16);
      drain(8'hAA);

      // Sustained streaming across several pointer wraps.
      s_tvalid = 1'b1; m_tready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         s_tdata = 8'(i); s_tlast = SF ? 1'b1 : (i % 8 == 7);
         tick();
         check($sformatf("stream%0d_count", i), 32'(count), 32'd1);
         check($sformatf("stream%0d_m_tvalid", i), 32'(m_tvalid), 32'd1);
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      tick();
      m_tready = 1'b0;
      check("stream_end_count", 32'(count), 32'd0);
      check("stream_end_last", 32'(last_pop_data), 32'd39);

      // Asynchronous reset between clock edges, mid-packet.
      for (int i = 0; i < 5; i++) begin
         s_tvalid = 1'b1; s_tdata = 8'(8'h50 + i); s_tlast = 1'b0;
         tick();
      end
      s_tvalid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("async_rst_m_tvalid", 32'(m_tvalid), 32'd0);
      check("async_rst_s_tready", 32'(s_tready), 32'd0);
      check("async_rst_count", 32'(count), 32'd0);
      check("async_rst_m_tdata", 32'(m_tdata), 32'd0);
      sb_q.delete();
      @(posedge clk);
      #3 rst = 1'b0;
      tick();
      check("after_rst_s_tready", 32'(s_tready), 32'd1);
      check("after_rst_m_tvalid", 32'(m_tvalid), 32'd0);
      s_tvalid = 1'b1; s_tdata = 8'hC1; s_tlast = 1'b0;
      tick();
      s_tdata = 8'hC2; s_tlast = 1'b1;
      tick();
      s_tvalid = 1'b0; s_tlast = 1'b0;
      check("new_pkt_count", 32'(count), 32'd2);
      check("new_pkt_head", 32'(m_tdata), 32'hC1);
      drain(8'hC2);

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
      // Output stays invalid until the packet's last word is stored.
      for (int i = 0; i < 4; i++) begin
         s_tvalid = 1'b1; s_tdata = 8'(8'h60 + i); s_tlast = (i == 3);
         tick();
         check($sformatf("sf4_%0d_m_tvalid", i), 32'(m_tvalid), 32'(i == 3));
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      drain(8'h63);

      // Packet longer than the FIFO drains once the FIFO fills.
      idx = 0; seen = 1'b0; m_tready = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (idx >= 20 && count == 0) break;
         if (idx < 20) begin
            s_tvalid = 1'b1; s_tdata = 8'(8'h80 + idx); s_tlast = (idx == 19); acc = s_tready;
         end else begin
            s_tvalid = 1'b0; s_tlast = 1'b0; acc = 1'b0;
         end
         tick();
         if (acc) idx++;
         if (m_tvalid && !seen) begin
            seen = 1'b1;
            check("sf20_rise_count", 32'(count), 32'd16);
         end
      end
      s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
      check("sf20_pushed", 32'(idx), 32'd20);
      check("sf20_seen_valid", 32'(seen), 32'd1);
      check("sf20_count", 32'(count), 32'd0);
      check("sf20_last", 32'(last_pop_data), 32'h93);
`endif

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
